// File: rtl/axis_downsizer_n.sv
// AXI-Stream width downsizer: splits one IN_W-bit word into up to IN_W/OUT_W
// OUT_W-bit sub-beats, LSB slice first. A per-word count trims partial words,
// and with EARLY_LAST set the word ends at the first sub-beat flagged tlast.
// A new word is accepted in the same cycle the final sub-beat leaves, so
// consecutive words stream without bubbles.
//
// state    | meaning
// ST_EMPTY | no word held, output invalid, input ready
// ST_EMIT  | presenting data_q[OUT_W-1:0] as the current sub-beat
module axis_downsizer_n #(
    parameter int IN_W       = 1536,
    parameter int OUT_W      = 128,
    parameter int EARLY_LAST = 1,
    localparam int N         = IN_W / OUT_W,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [N-1:0]     s_axis_tlast,
    input  logic [CW-1:0]    s_axis_tcnt,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam logic [0:0]    ST_EMPTY = 1'b0;
    localparam logic [0:0]    ST_EMIT  = 1'b1;
    localparam logic [CW-1:0] N_CW     = CW'(N);
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [CW-1:0] TWO_CW   = CW'(2);

    logic [0:0]      state_q, state_d;
    logic [IN_W-1:0] data_q, data_d;
    logic [N-1:0]    last_q, last_d;
    logic [CW-1:0]   rem_q, rem_d;

    logic            final_beat;
    logic            in_hs;
    logic            out_hs;
    logic [CW-1:0]   cnt_clamped;

    assign m_axis_tvalid = (state_q == ST_EMIT);
    assign m_axis_tdata  = data_q[OUT_W-1:0];
    assign m_axis_tlast  = last_q[0];

    // The current sub-beat closes the word when it is the last counted one,
    // or when early termination is enabled and it carries tlast.
    assign final_beat    = (rem_q == ONE_CW) | ((EARLY_LAST != 0) & last_q[0]);
    assign s_axis_tready = ~m_axis_tvalid | (m_axis_tready & final_beat);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;

    // Out-of-range counts (zero or above N) mean a full word.
    assign cnt_clamped   = ((s_axis_tcnt == '0) || (s_axis_tcnt > N_CW)) ? N_CW : s_axis_tcnt;

    // Next-state: load on input handshake, shift on a non-final output
    // handshake, fall to EMPTY when the final sub-beat leaves with no refill.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        rem_d   = rem_q;
        if (in_hs) begin
            state_d = ST_EMIT;
            data_d  = s_axis_tdata;
            last_d  = s_axis_tlast;
            rem_d   = cnt_clamped;
        end else if (out_hs) begin
            if (final_beat) begin
                state_d = ST_EMPTY;
            end else begin
                data_d = data_q >> OUT_W;
                last_d = last_q >> 1;
                if (rem_q >= TWO_CW) begin
                    rem_d = rem_q - ONE_CW;
                end
            end
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            last_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_axis_downsizer_n.sv
// Self-checking bench for axis_downsizer_n: directed scenarios plus a
// randomized stream compared against a queue-based reference model.
module tb_axis_downsizer_n;

    localparam int IN_W  = 1536;
    localparam int OUT_W = 128;
    localparam int N     = 12;
    localparam int CW    = 4;
    localparam int SIN_W = 512;
    localparam int SN    = 4;
    localparam int SCW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the EARLY_LAST=1 and EARLY_LAST=0 instances.
    logic [IN_W-1:0]  s_tdata  = '0;
    logic             s_tvalid = 1'b0;
    logic [N-1:0]     s_tlast  = '0;
    logic [CW-1:0]    s_tcnt   = '0;
    logic             m_tready = 1'b1;

    logic             s_tready0, m_tvalid0, m_tlast0;
    logic [OUT_W-1:0] m_tdata0;
    logic             s_tready1, m_tvalid1, m_tlast1;
    logic [OUT_W-1:0] m_tdata1;

    logic [SIN_W-1:0] ss_tdata  = '0;
    logic             ss_tvalid = 1'b0;
    logic [SN-1:0]    ss_tlast  = '0;
    logic [SCW-1:0]   ss_tcnt   = '0;
    logic             sm_tready = 1'b1;
    logic             s_tready2, m_tvalid2, m_tlast2;
    logic [OUT_W-1:0] m_tdata2;

    axis_downsizer_n #(.IN_W(IN_W), .OUT_W(OUT_W), .EARLY_LAST(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
        .s_axis_tlast(s_tlast), .s_axis_tcnt(s_tcnt),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast0)
    );

    axis_downsizer_n #(.IN_W(IN_W), .OUT_W(OUT_W), .EARLY_LAST(0)) dut_nel (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
        .s_axis_tlast(s_tlast), .s_axis_tcnt(s_tcnt),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast1)
    );

    axis_downsizer_n #(.IN_W(SIN_W), .OUT_W(OUT_W), .EARLY_LAST(1)) dut_small (
        .clk(clk), .rst(rst),
        .s_axis_tdata(ss_tdata), .s_axis_tvalid(ss_tvalid), .s_axis_tready(s_tready2),
        .s_axis_tlast(ss_tlast), .s_axis_tcnt(ss_tcnt),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(sm_tready),
        .m_axis_tlast(m_tlast2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
        logic             fin;
    } beat_t;

    beat_t q[$];

    function automatic logic [IN_W-1:0] seq_word(input logic [OUT_W-1:0] base);
        logic [IN_W-1:0] w;
        for (int k = 0; k < N; k++) w[k*OUT_W +: OUT_W] = base + OUT_W'(k);
        return w;
    endfunction

    function automatic logic [SIN_W-1:0] seq_word_s(input logic [OUT_W-1:0] base);
        logic [SIN_W-1:0] w;
        for (int k = 0; k < SN; k++) w[k*OUT_W +: OUT_W] = base + OUT_W'(k);
        return w;
    endfunction

    // Reference: expand a word into the sub-beats a downsizer must emit.
    function automatic void push_word(input logic [IN_W-1:0] d, input logic [N-1:0] l,
                                      input int cnt);
        int    c;
        beat_t b;
        c = (cnt == 0 || cnt > N) ? N : cnt;
        for (int k = 0; k < c; k++) begin
            b.d   = d[k*OUT_W +: OUT_W];
            b.l   = l[k];
            b.fin = (k == c - 1) || l[k];
            q.push_back(b);
            if (b.fin) break;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1; ss_tvalid = 1'b0; sm_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [IN_W-1:0] d, input logic [N-1:0] l, input int cnt);
        @(negedge clk);
        s_tdata = d; s_tlast = l; s_tcnt = CW'(cnt); s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (m_tvalid0 !== 1'b0 || m_tdata0 !== '0 || m_tlast0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b want v=0 d=0 l=0", m_tvalid0, m_tdata0, m_tlast0);
        end
        checks++;
        if (s_tready0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", s_tready0);
        end
        checks++;
        if (m_tvalid2 !== 1'b0 || s_tready2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_small: got v=%b rdy=%b want v=0 rdy=1", m_tvalid2, s_tready2);
        end
    endtask

    task automatic test_full_word();
        m_tready = 1'b1;
        send_word(seq_word('0), 12'h800, 12);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (m_tvalid0 !== 1'b1 || m_tdata0 !== OUT_W'(k) || m_tlast0 !== (k == N - 1)) begin
                failures++;
                $display("FAIL full_word beat %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, m_tvalid0, m_tdata0, m_tlast0, OUT_W'(k), (k == N - 1));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (m_tvalid0 !== 1'b0 || s_tready0 !== 1'b1) begin
            failures++;
            $display("FAIL full_word_end: got v=%b rdy=%b want v=0 rdy=1", m_tvalid0, s_tready0);
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] exp_d;
        m_tready = 1'b1;
        @(negedge clk);
        s_tdata = seq_word(128'h100); s_tlast = 12'h800; s_tcnt = 4'd12; s_tvalid = 1'b1;
        @(negedge clk);
        s_tdata = seq_word(128'h200);
        for (int k = 0; k < 2 * N; k++) begin
            #1;
            exp_d = (k < N) ? 128'h100 + OUT_W'(k) : 128'h200 + OUT_W'(k - N);
            checks++;
            if (m_tvalid0 !== 1'b1 || m_tdata0 !== exp_d) begin
                failures++;
                $display("FAIL b2b beat %0d: got v=%b d=%h want v=1 d=%h", k, m_tvalid0, m_tdata0, exp_d);
            end
            if (k < 2 * N - 1) begin
                checks++;
                if (s_tready0 !== (k == N - 1)) begin
                    failures++;
                    $display("FAIL b2b_ready beat %0d: got %b want %b", k, s_tready0, (k == N - 1));
                end
            end
            @(negedge clk);
            if (k == N - 1) s_tvalid = 1'b0;
        end
        checks++;
        if (m_tvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got v=%b want 0", m_tvalid0);
        end
    endtask

    task automatic test_counts();
        int cnts[3] = '{5, 0, 15};
        int exps[3] = '{5, 12, 12};
        int n;
        logic [OUT_W-1:0] base;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            base = 128'h400 + OUT_W'(i * 32);
            send_word(seq_word(base), '0, cnts[i]);
            n = 0;
            while (m_tvalid0 === 1'b1 && n < 20) begin
                checks++;
                if (m_tdata0 !== base + OUT_W'(n)) begin
                    failures++;
                    $display("FAIL count_data tcnt=%0d beat %0d: got %h want %h", cnts[i], n, m_tdata0, base + OUT_W'(n));
                end
                n++;
                @(negedge clk);
            end
            checks++;
            if (n != exps[i]) begin
                failures++;
                $display("FAIL count_beats tcnt=%0d: got %0d beats want %0d", cnts[i], n, exps[i]);
            end
        end
    endtask

    task automatic test_early_last();
        int n0 = 0, n1 = 0;
        logic [15:0] lm0 = '0, lm1 = '0;
        do_reset();
        send_word(seq_word(128'h500), 12'h008, 12);
        for (int c = 0; c < 16; c++) begin
            if (m_tvalid0 === 1'b1) begin
                checks++;
                if (m_tdata0 !== 128'h500 + OUT_W'(n0)) begin
                    failures++;
                    $display("FAIL early_data beat %0d: got %h want %h", n0, m_tdata0, 128'h500 + OUT_W'(n0));
                end
                lm0[n0 % 16] = m_tlast0;
                n0++;
            end
            if (m_tvalid1 === 1'b1) begin
                lm1[n1 % 16] = m_tlast1;
                n1++;
            end
            @(negedge clk);
        end
        checks++;
        if (n0 != 4 || lm0 !== 16'h0008) begin
            failures++;
            $display("FAIL early_last_on: got beats=%0d tlast=%h want beats=4 tlast=0008", n0, lm0);
        end
        checks++;
        if (n1 != 12 || lm1 !== 16'h0008) begin
            failures++;
            $display("FAIL early_last_off: got beats=%0d tlast=%h want beats=12 tlast=0008", n1, lm1);
        end
    endtask

    task automatic test_random();
        int words = 0;
        int cyc;
        logic exp_v, exp_rdy, acc, prev_stall;
        logic [OUT_W-1:0] prev_d;
        logic prev_l;
        do_reset();
        q.delete();
        acc = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            if (words == 200 && q.size() == 0 && !s_tvalid) break;
            if (acc) s_tvalid = 1'b0;
            acc = 1'b0;
            m_tready = 1'($urandom_range(0, 1));
            if (!s_tvalid && words < 200 && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < IN_W / 32; k++) s_tdata[k*32 +: 32] = $urandom;
                s_tlast  = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
                s_tcnt   = CW'($urandom_range(0, 15));
                s_tvalid = 1'b1;
            end
            #1;
            exp_v   = (q.size() != 0);
            exp_rdy = exp_v ? (m_tready && q[0].fin) : 1'b1;
            checks++;
            if (m_tvalid0 !== exp_v) begin
                failures++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, m_tvalid0, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (m_tdata0 !== q[0].d || m_tlast0 !== q[0].l) begin
                    failures++;
                    $display("FAIL rand_beat cyc %0d: got d=%h l=%b want d=%h l=%b", cyc, m_tdata0, m_tlast0, q[0].d, q[0].l);
                end
            end
            checks++;
            if (s_tready0 !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, s_tready0, exp_rdy);
            end
            if (prev_stall) begin
                checks++;
                if (m_tvalid0 !== 1'b1 || m_tdata0 !== prev_d || m_tlast0 !== prev_l) begin
                    failures++;
                    $display("FAIL rand_stall cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, m_tvalid0, m_tdata0, m_tlast0, prev_d, prev_l);
                end
            end
            prev_stall = (m_tvalid0 === 1'b1) && !m_tready;
            prev_d = m_tdata0;
            prev_l = m_tlast0;
            if (exp_v && m_tready) void'(q.pop_front());
            if (s_tvalid && exp_rdy) begin
                push_word(s_tdata, s_tlast, int'(s_tcnt));
                words++;
                acc = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (!(words == 200 && q.size() == 0)) begin
            failures++;
            $display("FAIL rand_timeout: got words=%0d pending=%0d want words=200 pending=0", words, q.size());
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(seq_word(128'h600), 12'h800, 12);
        for (int k = 0; k <= 6; k++) begin
            checks++;
            if (m_tvalid0 !== 1'b1 || m_tdata0 !== 128'h600 + OUT_W'(k)) begin
                failures++;
                $display("FAIL mid_pre beat %0d: got v=%b d=%h want v=1 d=%h", k, m_tvalid0, m_tdata0, 128'h600 + OUT_W'(k));
            end
            if (k < 6) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (m_tvalid0 !== 1'b0 || m_tdata0 !== '0 || s_tready0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", m_tvalid0, m_tdata0, s_tready0);
        end
        rst = 1'b0;
        send_word(seq_word(128'h700), 12'h800, 12);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_tvalid0 !== 1'b1 || m_tdata0 !== 128'h700 + OUT_W'(k)) begin
                failures++;
                $display("FAIL mid_after beat %0d: got v=%b d=%h want v=1 d=%h", k, m_tvalid0, m_tdata0, 128'h700 + OUT_W'(k));
            end
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_small();
        do_reset();
        ss_tdata = seq_word_s(128'h800); ss_tlast = 4'h8; ss_tcnt = 3'd4; ss_tvalid = 1'b1;
        @(negedge clk);
        ss_tvalid = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            checks++;
            if (m_tvalid2 !== 1'b1 || m_tdata2 !== 128'h800 + OUT_W'(k)) begin
                failures++;
                $display("FAIL small_pre beat %0d: got v=%b d=%h want v=1 d=%h", k, m_tvalid2, m_tdata2, 128'h800 + OUT_W'(k));
            end
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (m_tvalid2 !== 1'b0 || m_tdata2 !== '0 || s_tready2 !== 1'b1) begin
            failures++;
            $display("FAIL small_reset: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", m_tvalid2, m_tdata2, s_tready2);
        end
        rst = 1'b0;
        @(negedge clk);
        ss_tdata = seq_word_s(128'h900); ss_tvalid = 1'b1;
        @(negedge clk);
        ss_tvalid = 1'b0;
        for (int k = 0; k < SN; k++) begin
            checks++;
            if (m_tvalid2 !== 1'b1 || m_tdata2 !== 128'h900 + OUT_W'(k) || m_tlast2 !== (k == SN - 1)) begin
                failures++;
                $display("FAIL small_after beat %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, m_tvalid2, m_tdata2, m_tlast2, 128'h900 + OUT_W'(k), (k == SN - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (m_tvalid2 !== 1'b0) begin
            failures++;
            $display("FAIL small_end: got v=%b want 0", m_tvalid2);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_counts();
        test_early_last();
        test_random();
        test_reset_mid();
        test_reset_mid_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
